// File: rtl/pu_msp430_dpram_if.sv
// pu_msp430_dpram_if
//   Groups the two memory ports and the status flags of pu_msp430_dpram.
//   Ports A and B each carry:
//     x_cen  : chip enable, active low
//     x_wen  : byte write enables, active low, bit i = byte lane i
//     x_addr : word address
//     x_din  : write data
//     x_dout : read data
//     x_err  : one-cycle out-of-range flag aligned with the data slot
//   Status:
//     ram_busy : high while the memory is being cleared after reset
//     ram_coll : one-cycle pulse when both ports wrote the same word
//   master = the requester driving the ports, slave = the memory.
interface pu_msp430_dpram_if #(
  parameter int ADDR_MSB   = 6,
  parameter int DATA_WIDTH = 16
) ();

  localparam int BE = DATA_WIDTH / 8;

  logic                  a_cen;
  logic [BE-1:0]         a_wen;
  logic [ADDR_MSB:0]     a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic [DATA_WIDTH-1:0] a_dout;
  logic                  a_err;

  logic                  b_cen;
  logic [BE-1:0]         b_wen;
  logic [ADDR_MSB:0]     b_addr;
  logic [DATA_WIDTH-1:0] b_din;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_err;

  logic                  ram_busy;
  logic                  ram_coll;

  modport master (
    output a_cen, a_wen, a_addr, a_din,
    input  a_dout, a_err,
    output b_cen, b_wen, b_addr, b_din,
    input  b_dout, b_err,
    input  ram_busy, ram_coll
  );

  modport slave (
    input  a_cen, a_wen, a_addr, a_din,
    output a_dout, a_err,
    input  b_cen, b_wen, b_addr, b_din,
    output b_dout, b_err,
    output ram_busy, ram_coll
  );

endinterface

// File: rtl/pu_msp430_dpram.sv
// pu_msp430_dpram
//   True dual-port, byte-writable RAM with a power-on clear sequencer.
//   After reset the whole array is written to zero, one word per cycle,
//   while ram_busy is high; accesses are ignored during that time.
//   Reads are write-first: a port reading a word that either port writes
//   in the same cycle sees the merged result (port A wins per lane).
// Ports:
//   ram_clk : single clock for both ports and the clear sequencer
//   ram_rst : asynchronous active-high reset, restarts the clear
//   bus     : slave side of pu_msp430_dpram_if (ports A/B, busy, coll)
module pu_msp430_dpram #(
  parameter int ADDR_MSB   = 6,
  parameter int MEM_SIZE   = 256,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_REG    = 0
) (
  input  logic              ram_clk,
  input  logic              ram_rst,
  pu_msp430_dpram_if.slave  bus
);

  localparam int BE    = DATA_WIDTH / 8;
  localparam int WORDS = MEM_SIZE / BE;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {INIT, READY} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      cnt, cnt_next;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [ADDR_MSB:0]     a_addr, b_addr;
  logic                  a_act, b_act, a_ok, b_ok;
  logic [BE-1:0]         a_we, b_we;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic                  same_addr, coll;
  logic [DATA_WIDTH-1:0] a_rd, b_rd;

  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  a_err_q, b_err_q, coll_q;

  assign a_addr = bus.a_addr;
  assign b_addr = bus.b_addr;

  // Clear sequencer state register.
  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter stops on the last word so it never wraps once READY.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      INIT: begin
        if (cnt == IDX_W'(WORDS - 1)) state_next = READY;
        else                          cnt_next   = cnt + 1'b1;
      end
      READY: ;
      default: state_next = INIT;
    endcase
  end

  assign bus.ram_busy = (state == INIT);

  // Access decode. Out-of-range accesses get a zero lane mask and index 0
  // so they can never touch the array.
  always_comb begin
    a_act     = (state == READY) && !bus.a_cen;
    b_act     = (state == READY) && !bus.b_cen;
    a_ok      = a_act && (32'(a_addr) < 32'(WORDS));
    b_ok      = b_act && (32'(b_addr) < 32'(WORDS));
    a_we      = a_ok ? ~bus.a_wen : '0;
    b_we      = b_ok ? ~bus.b_wen : '0;
    a_idx     = a_ok ? IDX_W'(a_addr) : '0;
    b_idx     = b_ok ? IDX_W'(b_addr) : '0;
    same_addr = (a_addr == b_addr);
    coll      = a_ok && b_ok && same_addr && (|a_we) && (|b_we);
  end

  // Merged view of each addressed word after this cycle's writes. The same
  // value is both the write-first read data and the word written back, so
  // two writes to one address store identical data.
  always_comb begin
    a_rd = mem[a_idx];
    b_rd = mem[b_idx];
    for (int i = 0; i < BE; i++) begin
      if (b_we[i] && same_addr) a_rd[8*i +: 8] = bus.b_din[8*i +: 8];
      if (a_we[i])              a_rd[8*i +: 8] = bus.a_din[8*i +: 8];
      if (b_we[i])              b_rd[8*i +: 8] = bus.b_din[8*i +: 8];
      if (a_we[i] && same_addr) b_rd[8*i +: 8] = bus.a_din[8*i +: 8];
    end
  end

  // Storage array; deliberately not reset, the sequencer clears it.
  always_ff @(posedge ram_clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else begin
      if (|b_we) mem[b_idx] <= b_rd;
      if (|a_we) mem[a_idx] <= a_rd;
    end
  end

  // First read stage. Data holds when a port is idle; err and coll pulse.
  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      if (a_act) a_q <= a_ok ? a_rd : '0;
      if (b_act) b_q <= b_ok ? b_rd : '0;
      a_err_q <= a_act && !a_ok;
      b_err_q <= b_act && !b_ok;
      coll_q  <= coll;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] a_q2, b_q2;
      logic                  a_err_q2, b_err_q2, coll_q2;

      // Optional output stage: a plain copy of stage one, one cycle later.
      always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
          a_q2     <= '0;
          b_q2     <= '0;
          a_err_q2 <= 1'b0;
          b_err_q2 <= 1'b0;
          coll_q2  <= 1'b0;
        end else begin
          a_q2     <= a_q;
          b_q2     <= b_q;
          a_err_q2 <= a_err_q;
          b_err_q2 <= b_err_q;
          coll_q2  <= coll_q;
        end
      end

      assign bus.a_dout   = a_q2;
      assign bus.b_dout   = b_q2;
      assign bus.a_err    = a_err_q2;
      assign bus.b_err    = b_err_q2;
      assign bus.ram_coll = coll_q2;
    end else begin : g_no_out_reg
      assign bus.a_dout   = a_q;
      assign bus.b_dout   = b_q;
      assign bus.a_err    = a_err_q;
      assign bus.b_err    = b_err_q;
      assign bus.ram_coll = coll_q;
    end
  endgenerate

endmodule

// File: tb/tb_pu_msp430_dpram.sv
// tb_pu_msp430_dpram
//   Directed bench for pu_msp430_dpram. dut0 uses the defaults (128 words,
//   1-cycle latency); dut1 has MEM_SIZE=128 (64 words) and OUT_REG=1 so the
//   out-of-range and 2-cycle latency behaviour can be exercised.
module tb_pu_msp430_dpram;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n0, n1;

  always #5 clk = ~clk;

  pu_msp430_dpram_if #(.ADDR_MSB(6), .DATA_WIDTH(16)) bus0 ();
  pu_msp430_dpram_if #(.ADDR_MSB(6), .DATA_WIDTH(16)) bus1 ();

  pu_msp430_dpram #(
    .ADDR_MSB(6), .MEM_SIZE(256), .DATA_WIDTH(16), .OUT_REG(0)
  ) dut0 (
    .ram_clk (clk),
    .ram_rst (rst),
    .bus     (bus0)
  );

  pu_msp430_dpram #(
    .ADDR_MSB(6), .MEM_SIZE(128), .DATA_WIDTH(16), .OUT_REG(1)
  ) dut1 (
    .ram_clk (clk),
    .ram_rst (rst),
    .bus     (bus1)
  );

  // Drives both ports of one DUT; sel 0 = dut0, 1 = dut1.
  task automatic applyStimulus(input int sel,
                               input logic ac, input logic [1:0] aw,
                               input logic [6:0] aa, input logic [15:0] ad,
                               input logic bc, input logic [1:0] bw,
                               input logic [6:0] ba, input logic [15:0] bd);
    if (sel == 0) begin
      bus0.a_cen = ac; bus0.a_wen = aw; bus0.a_addr = aa; bus0.a_din = ad;
      bus0.b_cen = bc; bus0.b_wen = bw; bus0.b_addr = ba; bus0.b_din = bd;
    end else begin
      bus1.a_cen = ac; bus1.a_wen = aw; bus1.a_addr = aa; bus1.a_din = ad;
      bus1.b_cen = bc; bus1.b_wen = bw; bus1.b_addr = ba; bus1.b_din = bd;
    end
  endtask

  task automatic idleAll();
    applyStimulus(0, 1'b1, 2'b11, 7'h00, 16'h0000, 1'b1, 2'b11, 7'h00, 16'h0000);
    applyStimulus(1, 1'b1, 2'b11, 7'h00, 16'h0000, 1'b1, 2'b11, 7'h00, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Counts edges after reset release until each DUT drops ram_busy.
  task automatic waitReady(output int c0, output int c1);
    c0 = -1;
    c1 = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c0 < 0 && !bus0.ram_busy) c0 = c;
      if (c1 < 0 && !bus1.ram_busy) c1 = c;
      if (c0 >= 0 && c1 >= 0) break;
    end
  endtask

  task automatic readAllZero(input string phase);
    for (int i = 0; i < 128; i++) begin
      applyStimulus(0, 1'b0, 2'b11, 7'(i), 16'h0000, 1'b1, 2'b11, 7'h00, 16'h0000);
      tick();
      checkOutput($sformatf("%s_word%0d", phase, i), {16'h0, bus0.a_dout}, 32'h0);
    end
    checkOutput({phase, "_err_top"}, {31'h0, bus0.a_err}, 32'h0);
    idleAll();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleAll();
    rst = 1'b1;
    #12;
    checkOutput("rst_busy0",  {31'h0, bus0.ram_busy}, 32'h1);
    checkOutput("rst_adout0", {16'h0, bus0.a_dout},   32'h0);
    checkOutput("rst_bdout0", {16'h0, bus0.b_dout},   32'h0);
    checkOutput("rst_aerr0",  {31'h0, bus0.a_err},    32'h0);
    checkOutput("rst_coll0",  {31'h0, bus0.ram_coll}, 32'h0);
    checkOutput("rst_busy1",  {31'h0, bus1.ram_busy}, 32'h1);
    checkOutput("rst_adout1", {16'h0, bus1.a_dout},   32'h0);
    tick();
    rst = 1'b0;

    waitReady(n0, n1);
    checkOutput("init_cycles0", n0, 128);
    checkOutput("init_cycles1", n1, 64);
    readAllZero("init");

    // dut0: byte-lane writes, write-first, collision, independent ports.
    applyStimulus(0, 1'b0, 2'b00, 7'd5, 16'h1234, 1'b1, 2'b11, 7'd0, 16'h0000);
    tick();
    checkOutput("wr5_full_adout", {16'h0, bus0.a_dout}, 32'h1234);
    applyStimulus(0, 1'b0, 2'b10, 7'd5, 16'hABCD, 1'b1, 2'b11, 7'd0, 16'h0000);
    tick();
    checkOutput("wr5_lane0_adout", {16'h0, bus0.a_dout}, 32'h12CD);
    applyStimulus(0, 1'b1, 2'b11, 7'd0, 16'h0000, 1'b0, 2'b11, 7'd5, 16'h0000);
    tick();
    checkOutput("rd5_bdout", {16'h0, bus0.b_dout}, 32'h12CD);
    checkOutput("hold_adout", {16'h0, bus0.a_dout}, 32'h12CD);

    applyStimulus(0, 1'b0, 2'b10, 7'd9, 16'h00AA, 1'b0, 2'b00, 7'd9, 16'h5566);
    tick();
    checkOutput("coll_pulse", {31'h0, bus0.ram_coll}, 32'h1);
    checkOutput("coll_adout", {16'h0, bus0.a_dout}, 32'h55AA);
    checkOutput("coll_bdout", {16'h0, bus0.b_dout}, 32'h55AA);
    applyStimulus(0, 1'b0, 2'b11, 7'd9, 16'h0000, 1'b1, 2'b11, 7'd0, 16'h0000);
    tick();
    checkOutput("coll_end", {31'h0, bus0.ram_coll}, 32'h0);
    checkOutput("rd9_adout", {16'h0, bus0.a_dout}, 32'h55AA);

    applyStimulus(0, 1'b0, 2'b00, 7'd3, 16'hBEEF, 1'b0, 2'b11, 7'd3, 16'h0000);
    tick();
    checkOutput("wfirst_bdout", {16'h0, bus0.b_dout}, 32'hBEEF);
    checkOutput("wfirst_nocoll", {31'h0, bus0.ram_coll}, 32'h0);

    applyStimulus(0, 1'b0, 2'b11, 7'd5, 16'h0000, 1'b0, 2'b00, 7'd7, 16'h7777);
    tick();
    checkOutput("indep_adout", {16'h0, bus0.a_dout}, 32'h12CD);
    checkOutput("indep_bdout", {16'h0, bus0.b_dout}, 32'h7777);
    applyStimulus(0, 1'b0, 2'b11, 7'd9, 16'h0000, 1'b0, 2'b11, 7'd7, 16'h0000);
    tick();
    checkOutput("dualrd_adout", {16'h0, bus0.a_dout}, 32'h55AA);
    checkOutput("dualrd_bdout", {16'h0, bus0.b_dout}, 32'h7777);

    applyStimulus(0, 1'b1, 2'b11, 7'd0, 16'h0000, 1'b0, 2'b00, 7'h7F, 16'hC3C3);
    tick();
    applyStimulus(0, 1'b0, 2'b11, 7'h7F, 16'h0000, 1'b0, 2'b11, 7'd3, 16'h0000);
    tick();
    checkOutput("top_adout", {16'h0, bus0.a_dout}, 32'hC3C3);
    checkOutput("top_aerr", {31'h0, bus0.a_err}, 32'h0);
    checkOutput("rd3_bdout", {16'h0, bus0.b_dout}, 32'hBEEF);
    idleAll();

    // dut1: 2-cycle latency, out-of-range access, delayed collision.
    applyStimulus(1, 1'b0, 2'b00, 7'd5, 16'h1234, 1'b1, 2'b11, 7'd0, 16'h0000);
    tick();
    checkOutput("oreg_lat1", {16'h0, bus1.a_dout}, 32'h0);
    applyStimulus(1, 1'b0, 2'b10, 7'd5, 16'hABCD, 1'b1, 2'b11, 7'd0, 16'h0000);
    tick();
    checkOutput("oreg_lat2", {16'h0, bus1.a_dout}, 32'h1234);
    applyStimulus(1, 1'b1, 2'b11, 7'd0, 16'h0000, 1'b0, 2'b11, 7'd5, 16'h0000);
    tick();
    checkOutput("oreg_lane_adout", {16'h0, bus1.a_dout}, 32'h12CD);
    checkOutput("oreg_b_early", {16'h0, bus1.b_dout}, 32'h0);
    applyStimulus(1, 1'b0, 2'b00, 7'h40, 16'hFFFF, 1'b1, 2'b11, 7'd0, 16'h0000);
    tick();
    checkOutput("oreg_b_rd5", {16'h0, bus1.b_dout}, 32'h12CD);
    checkOutput("oor_err_early", {31'h0, bus1.a_err}, 32'h0);
    applyStimulus(1, 1'b0, 2'b11, 7'd0, 16'h0000, 1'b1, 2'b11, 7'd0, 16'h0000);
    tick();
    checkOutput("oor_dout", {16'h0, bus1.a_dout}, 32'h0);
    checkOutput("oor_err", {31'h0, bus1.a_err}, 32'h1);
    idleAll();
    tick();
    checkOutput("oor_word0_kept", {16'h0, bus1.a_dout}, 32'h0);
    checkOutput("oor_err_pulse", {31'h0, bus1.a_err}, 32'h0);
    applyStimulus(1, 1'b0, 2'b10, 7'd9, 16'h00AA, 1'b0, 2'b00, 7'd9, 16'h5566);
    tick();
    checkOutput("oreg_coll_early", {31'h0, bus1.ram_coll}, 32'h0);
    idleAll();
    tick();
    checkOutput("oreg_coll", {31'h0, bus1.ram_coll}, 32'h1);
    checkOutput("oreg_coll_data", {16'h0, bus1.a_dout}, 32'h55AA);
    tick();
    checkOutput("oreg_coll_end", {31'h0, bus1.ram_coll}, 32'h0);

    // Reset mid-operation, then again 40 cycles into the clear.
    rst = 1'b1;
    #1;
    checkOutput("midop_rst_adout", {16'h0, bus0.a_dout}, 32'h0);
    checkOutput("midop_rst_bdout", {16'h0, bus0.b_dout}, 32'h0);
    checkOutput("midop_rst_busy", {31'h0, bus0.ram_busy}, 32'h1);
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b0, 2'b00, 7'd9, 16'hFFFF, 1'b0, 2'b00, 7'd9, 16'hEEEE);
    for (int i = 0; i < 40; i++) tick();
    checkOutput("init_busy40", {31'h0, bus0.ram_busy}, 32'h1);
    checkOutput("init_ignored_dout", {16'h0, bus0.a_dout}, 32'h0);
    checkOutput("init_ignored_coll", {31'h0, bus0.ram_coll}, 32'h0);
    idleAll();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    waitReady(n0, n1);
    checkOutput("reinit_cycles0", n0, 128);
    checkOutput("reinit_cycles1", n1, 64);
    readAllZero("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
